// File: rtl/clksel_ctrl_if.sv
// Control-side handshake between the request source and the clock-select sequencer.
interface clksel_ctrl_if;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] cur_sel;

  // Requester side
  modport master (
    output req_valid, req_sel,
    input  req_ready, busy, done, err, cur_sel
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_sel,
    output req_ready, busy, done, err, cur_sel
  );
endinterface

// File: rtl/clksel_ctrl.sv
// Glitchless clock-source switch sequencer: accepts a select request, drives the
// registered clksel, lets the switch settle, then confirms the new clock by counting
// transitions of a toggle from the clkout domain. A dead clock reverts to FALLBACK_SEL.
module clksel_ctrl #(
  parameter int         SETTLE       = 16,
  parameter int         WINDOW       = 64,
  parameter int         MIN_EDGES    = 8,
  parameter logic [1:0] FALLBACK_SEL = 2'b00
) (
  input  logic         clk,
  input  logic         coldres,
  clksel_ctrl_if.slave ctl,
  input  logic         clkout_mon,
  output logic [1:0]   clksel
);

  localparam int CNT_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] WINDOW_LAST = CW'(WINDOW - 1);
  localparam logic [7:0]    EDGE_TGT    = 8'(MIN_EDGES);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_VERIFY   = 2'd2;
  localparam logic [1:0] ST_FALLBACK = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    edges_q, edges_d;
  logic [1:0]    target_q, target_d;
  logic [1:0]    clksel_q, clksel_d;
  logic [1:0]    cur_sel_q, cur_sel_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // [0],[1] form the synchronizer; [2] is the history flop for edge detection
  logic [2:0] mon_q;
  logic       edge_stb;
  logic [7:0] edges_inc;

  assign edge_stb  = mon_q[1] ^ mon_q[2];
  // Saturating edge count including this cycle's strobe
  assign edges_inc = (edge_stb && (edges_q != EDGE_TGT)) ? edges_q + 8'd1 : edges_q;

  // Resynchronize the clkout-domain toggle and keep one cycle of history
  always_ff @(posedge clk) begin
    if (coldres) mon_q <= 3'b000;
    else         mon_q <= {mon_q[1:0], clkout_mon};
  end

  // Next-state logic for the switch sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edges_d   = edges_q;
    target_d  = target_q;
    clksel_d  = clksel_q;
    cur_sel_d = cur_sel_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ctl.req_valid) begin
          if (ctl.req_sel == cur_sel_q) begin
            // Already running on that source: acknowledge without touching clksel
            done_d = 1'b1;
          end else begin
            target_d = ctl.req_sel;
            clksel_d = ctl.req_sel;
            err_d    = 1'b0;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
            cnt_d    = '0;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          edges_d = '0;
          state_d = ST_VERIFY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_VERIFY: begin
        cnt_d   = cnt_q + 1'b1;
        edges_d = edges_inc;
        // Success is tested first so reaching MIN_EDGES on the last window cycle still passes
        if (edges_inc == EDGE_TGT) begin
          cur_sel_d = target_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          ready_d   = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (cnt_q == WINDOW_LAST) begin
          clksel_d = FALLBACK_SEL;
          err_d    = 1'b1;
          cnt_d    = '0;
          state_d  = ST_FALLBACK;
        end
      end
      ST_FALLBACK: begin
        // Fallback source is trusted; just let the switch settle
        if (cnt_q == SETTLE_LAST) begin
          cur_sel_d = FALLBACK_SEL;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          ready_d   = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (coldres) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      edges_q   <= '0;
      target_q  <= FALLBACK_SEL;
      clksel_q  <= FALLBACK_SEL;
      cur_sel_q <= FALLBACK_SEL;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edges_q   <= edges_d;
      target_q  <= target_d;
      clksel_q  <= clksel_d;
      cur_sel_q <= cur_sel_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign clksel        = clksel_q;
  assign ctl.cur_sel   = cur_sel_q;
  assign ctl.busy      = busy_q;
  assign ctl.req_ready = ready_q;
  assign ctl.done      = done_q;
  assign ctl.err       = err_q;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Directed bench for clksel_ctrl with hand-computed cycle expectations.
module tb_clksel_ctrl;
  logic       clk = 1'b0;
  logic       coldres = 1'b1;
  logic       clkout_mon = 1'b0;
  logic       mon_en = 1'b0;
  logic [1:0] clksel;
  int         tests = 0;
  int         fails = 0;
  int         mon_div = 0;

  clksel_ctrl_if bus();

  clksel_ctrl #(
    .SETTLE(16), .WINDOW(64), .MIN_EDGES(8), .FALLBACK_SEL(2'b00)
  ) dut (
    .clk(clk),
    .coldres(coldres),
    .ctl(bus),
    .clkout_mon(clkout_mon),
    .clksel(clksel)
  );

  always #5 clk = ~clk;

  // Monitor toggle: flips every 2 clk cycles while enabled, stuck otherwise
  always @(negedge clk) begin
    if (mon_en) begin
      mon_div = mon_div + 1;
      if (mon_div % 2 == 0) clkout_mon = ~clkout_mon;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge; returns 1ns after the sampling edge
  task automatic send(input logic [1:0] s);
    bus.req_valid = 1'b1;
    bus.req_sel   = s;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int  cyc;
    int  done_first;
    int  bad;
    logic glitch;
    logic saw_done;

    bus.req_valid = 1'b0;
    bus.req_sel   = 2'b00;

    // Reset with the monitor toggling
    coldres = 1'b1;
    mon_en  = 1'b1;
    tick();
    tick();
    check("rst_clksel", 32'(clksel), 32'h0);
    check("rst_cur_sel", 32'(bus.cur_sel), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    coldres = 1'b0;
    tick();

    // Good switch to 01 with a live clock
    send(2'b01);
    check("good_acc_clksel", 32'(clksel), 32'h1);
    check("good_acc_busy", 32'(bus.busy), 32'h1);
    check("good_acc_ready", 32'(bus.req_ready), 32'h0);
    check("good_acc_err", 32'(bus.err), 32'h0);
    glitch = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 120) begin
      tick();
      cyc++;
      if (clksel !== 2'b01) glitch = 1'b1;
    end
    check("good_done_seen", 32'(bus.done), 32'h1);
    check("good_no_glitch", 32'(glitch), 32'h0);
    check("good_done_after_settle", 32'(cyc >= 20 && cyc <= 40), 32'h1);
    check("good_cur_sel", 32'(bus.cur_sel), 32'h1);
    check("good_done_busy", 32'(bus.busy), 32'h0);
    check("good_done_ready", 32'(bus.req_ready), 32'h1);
    check("good_err", 32'(bus.err), 32'h0);
    tick();
    check("good_done_one_cycle", 32'(bus.done), 32'h0);

    // Same-source request: immediate done, no sequence
    send(2'b01);
    check("same_done", 32'(bus.done), 32'h1);
    check("same_busy", 32'(bus.busy), 32'h0);
    check("same_clksel", 32'(clksel), 32'h1);
    tick();
    check("same_done_off", 32'(bus.done), 32'h0);
    check("same_busy_off", 32'(bus.busy), 32'h0);

    // Dead clock: switch to 10 with the monitor stuck
    mon_en = 1'b0;
    send(2'b10);
    done_first = -1;
    bad = 0;
    for (int c = 1; c <= 96; c++) begin
      tick();
      if (c < 80 && clksel !== 2'b10) bad++;
      if (c >= 80 && clksel !== 2'b00) bad++;
      if (c < 96 && bus.busy !== 1'b1) bad++;
      if (c == 79) begin
        check("dead_c79_clksel", 32'(clksel), 32'h2);
        check("dead_c79_err", 32'(bus.err), 32'h0);
      end
      if (c == 80) begin
        check("dead_c80_clksel", 32'(clksel), 32'h0);
        check("dead_c80_err", 32'(bus.err), 32'h1);
      end
      if (bus.done && done_first < 0) done_first = c;
    end
    check("dead_seq_violations", 32'(bad), 32'h0);
    check("dead_done_cycle", 32'(done_first), 32'd96);
    check("dead_cur_sel", 32'(bus.cur_sel), 32'h0);
    check("dead_err", 32'(bus.err), 32'h1);
    check("dead_ready", 32'(bus.req_ready), 32'h1);
    tick();
    tick();
    tick();
    check("dead_err_sticky", 32'(bus.err), 32'h1);
    send(2'b00);
    check("dead_same_done", 32'(bus.done), 32'h1);
    check("dead_same_err_kept", 32'(bus.err), 32'h1);
    tick();

    // Request during busy is ignored
    mon_en = 1'b1;
    send(2'b01);
    check("busy_acc_err_clr", 32'(bus.err), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'b11;
    tick();
    bus.req_valid = 1'b0;
    check("busy_ignored_clksel", 32'(clksel), 32'h1);
    cyc = 0;
    while (!bus.done && cyc < 120) begin
      tick();
      cyc++;
    end
    check("busy_done_seen", 32'(bus.done), 32'h1);
    check("busy_cur_sel", 32'(bus.cur_sel), 32'h1);
    check("busy_clksel", 32'(clksel), 32'h1);
    tick();

    // Reset in the middle of VERIFY
    mon_en = 1'b0;
    send(2'b10);
    saw_done = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    check("mid_pre_clksel", 32'(clksel), 32'h2);
    coldres = 1'b1;
    tick();
    if (bus.done) saw_done = 1'b1;
    check("mid_rst_clksel", 32'(clksel), 32'h0);
    check("mid_rst_cur_sel", 32'(bus.cur_sel), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_err", 32'(bus.err), 32'h0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'h1);
    coldres = 1'b0;
    tick();
    if (bus.done) saw_done = 1'b1;
    check("mid_no_done", 32'(saw_done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clksel_ctrl.md
Name: clksel_ctrl

Overview:
- Sequencer for the glitchless clock-source switch (clk24in/clk20in -> clkout, selected by clksel1:clksel0).
- Accepts clock-source change requests from the control side and drives the 2-bit select.
- Waits for the switch to settle, then verifies clkout activity through a monitor toggle.
- On failure, reverts to a fallback source and flags an error.

Parameters:
- SETTLE, 16, cycles of clk to hold after a select change before verification starts (≥2).
- WINDOW, 64, verification window length in clk cycles (≥MIN_EDGES+3).
- MIN_EDGES, 8, monitor transitions required inside WINDOW to declare the new clock alive (1..255).
- FALLBACK_SEL, 2'b00, select value used after reset and after a failed switch.

Ports:
- clk  in  1  free-running controller clock.
- coldres  in  1  synchronous, active-high reset.
- req_valid  in  1  switch request strobe.
- req_sel  in  2  requested source, sampled with req_valid.
- req_ready  out  1  controller can accept a request.
- clksel  out  2  registered select to the clock switch (bit0 -> clksel0, bit1 -> clksel1).
- clkout_mon  in  1  toggle generated in the clkout domain; asynchronous to clk.
- busy  out  1  switch sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  last switch failed; sticky.
- cur_sel  out  2  source confirmed as running.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (coldres).

Reset (coldres=1 at a clk edge, regardless of state):
- clksel=cur_sel=FALLBACK_SEL, req_ready=1, busy=0, done=0, err=0.
- State IDLE; all counters 0; synchronizer flops 0.
- Reset mid-sequence aborts immediately; no done pulse.

Monitor path:
- clkout_mon passes through a 2-flop synchronizer, then a third flop for edge detection.
- Each transition (either polarity) yields a one-cycle edge strobe, 3 cycles after the input change.
- The edge counter is cleared on VERIFY entry and saturates at MIN_EDGES.

States:
- IDLE:
  - req_ready=1, busy=0.
  - On edge T with req_valid=1: if req_sel==cur_sel, no select change; done=1 for cycle T+1; stay IDLE.
  - Else latch target=req_sel; at edge T, clksel<=target, err<=0, busy<=1, req_ready<=0; go SETTLE.
- SETTLE: count SETTLE cycles, then VERIFY with cycle and edge counters cleared. Monitor edges are ignored.
- VERIFY:
  - Count cycles and edges.
  - Edge count reaches MIN_EDGES -> cur_sel<=target, done pulse, go IDLE (early exit allowed).
  - If WINDOW cycles elapse first -> go FALLBACK.
  - If MIN_EDGES is reached on the final window cycle, success wins.
- FALLBACK:
  - clksel<=FALLBACK_SEL, err<=1; wait SETTLE cycles (no verification).
  - Then cur_sel<=FALLBACK_SEL, done pulse, go IDLE.
  - If target==FALLBACK_SEL itself failed: same path; err=1; clksel unchanged.

Handshake and outputs:
- done is high for exactly one cycle, coincident with return to IDLE (req_ready=1, busy=0 in that same cycle).
- A request may be accepted in the done cycle.
- req_valid while req_ready=0 is ignored, not queued.
- err holds until the next accepted request that changes the select, or reset.
- clksel changes only on the acceptance edge or on FALLBACK entry; never in any other cycle.
- Counters are wide enough for max(SETTLE, WINDOW) without wrap; no wrap-around behaviour exists.

Test Plan:
- Reset: hold coldres 2 cycles with clkout_mon toggling -> clksel=00, cur_sel=00, req_ready=1, busy=0, done=0, err=0.
- Good switch: req_sel=01 at edge T, clkout_mon toggling every 2 clk cycles -> clksel=01 from T, busy=1, VERIFY at T+16, done at ~T+16+3+16, cur_sel=01, err=0, clksel never glitches through 00/10/11.
- Dead clock: req_sel=10, clkout_mon stuck 0 -> clksel=10 until T+16+64, then 00 with err=1; done at T+96, cur_sel=00, err stays 1 until the next switch request.
- Same-source request: cur_sel=01, req_sel=01 -> done pulse at T+1, busy never asserted, clksel constant, err unchanged.
- Request during busy: req_valid with req_sel=11 while in SETTLE -> ignored; after done, cur_sel equals the original target, not 11.
- Reset mid-VERIFY: coldres at VERIFY cycle 10 -> next edge clksel=00, cur_sel=00, busy=0, err=0, no done pulse.
